// File: rtl/spi_pkg.sv
// Shared types and divider decode constants for the 16-bit mode-3 SPI master.
// Decode values are functions of the divider width so every legal width shares one definition.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FRONT_PORCH = 2'd1,
        SHIFT       = 2'd2,
        BACK_PORCH  = 2'd3
    } spi_state_e;

    localparam logic [4:0] PORCH_LAST    = 5'd8;
    localparam logic [4:0] LAST_RISE_CNT = 5'd15;

    function automatic logic [7:0] front_porch_load(input int w);
        return 8'((32'd1 << w) - 32'd9);
    endfunction

    function automatic logic [7:0] rise_decode(input int w);
        return 8'((32'd1 << (w - 1)) - 32'd1);
    endfunction

    function automatic logic [7:0] fall_decode(input int w);
        return 8'((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/spi_mstr_seq16.sv
// 16-bit SPI master, mode 3 (SCLK idles high, MOSI changes on fall, MISO sampled on rise).
// One frame per accepted wrt; done and rd_data hold until the next accepted request.
module spi_mstr_seq16
    import spi_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    localparam logic [SCLK_DIV_W-1:0] FRONT_PORCH_LOAD = SCLK_DIV_W'(front_porch_load(SCLK_DIV_W));
    localparam logic [SCLK_DIV_W-1:0] RISE_DEC         = SCLK_DIV_W'(rise_decode(SCLK_DIV_W));
    localparam logic [SCLK_DIV_W-1:0] FALL_DEC         = SCLK_DIV_W'(fall_decode(SCLK_DIV_W));
    localparam logic [SCLK_DIV_W-1:0] DIV_ONE          = SCLK_DIV_W'(1);

    spi_state_e            state_r, state_nxt;
    logic [SCLK_DIV_W-1:0] div_r, div_nxt;
    logic [4:0]            bit_cnt_r, bit_cnt_nxt;
    logic [15:0]           shft_reg_r, shft_reg_nxt;
    logic                  miso_smpl_r, miso_smpl_nxt;
    logic                  ss_n_r, ss_n_nxt;
    logic                  done_r, done_nxt;
    logic                  sclk_r, sclk_nxt;

    // State, divider, shifter and framing registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            div_r       <= '0;
            bit_cnt_r   <= 5'd0;
            shft_reg_r  <= 16'h0000;
            miso_smpl_r <= 1'b0;
            ss_n_r      <= 1'b1;
            done_r      <= 1'b0;
            sclk_r      <= 1'b1;
        end else begin
            state_r     <= state_nxt;
            div_r       <= div_nxt;
            bit_cnt_r   <= bit_cnt_nxt;
            shft_reg_r  <= shft_reg_nxt;
            miso_smpl_r <= miso_smpl_nxt;
            ss_n_r      <= ss_n_nxt;
            done_r      <= done_nxt;
            sclk_r      <= sclk_nxt;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_nxt     = state_r;
        div_nxt       = div_r;
        bit_cnt_nxt   = bit_cnt_r;
        shft_reg_nxt  = shft_reg_r;
        miso_smpl_nxt = miso_smpl_r;
        ss_n_nxt      = ss_n_r;
        done_nxt      = done_r;

        case (state_r)
            IDLE: begin
                if (wrt) begin
                    shft_reg_nxt = cmd;
                    div_nxt      = FRONT_PORCH_LOAD;
                    bit_cnt_nxt  = 5'd0;
                    done_nxt     = 1'b0;
                    ss_n_nxt     = 1'b0;
                    state_nxt    = FRONT_PORCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FRONT_PORCH: begin
                // bit_cnt times the porch so its length is 9 clocks at every divider width
                div_nxt = div_r + DIV_ONE;
                if (bit_cnt_r == PORCH_LAST) begin
                    div_nxt     = '0;
                    bit_cnt_nxt = 5'd0;
                    state_nxt   = SHIFT;
                end else begin
                    bit_cnt_nxt = bit_cnt_r + 5'd1;
                end
            end
            SHIFT: begin
                div_nxt = div_r + DIV_ONE;
                if (div_r == RISE_DEC) begin
                    miso_smpl_nxt = MISO;
                    bit_cnt_nxt   = bit_cnt_r + 5'd1;
                    if (bit_cnt_r == LAST_RISE_CNT) begin
                        state_nxt = BACK_PORCH;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end else if (div_r == FALL_DEC) begin
                    shft_reg_nxt = {shft_reg_r[14:0], miso_smpl_r};
                end else begin
                    shft_reg_nxt = shft_reg_r;
                end
            end
            BACK_PORCH: begin
                // Last shift lands with SS_n release; SCLK stays high, so no 17th fall
                div_nxt = div_r + DIV_ONE;
                if (div_r == FALL_DEC) begin
                    shft_reg_nxt = {shft_reg_r[14:0], miso_smpl_r};
                    ss_n_nxt     = 1'b1;
                    done_nxt     = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    state_nxt = BACK_PORCH;
                end
            end
            default: begin
                state_nxt = IDLE;
                ss_n_nxt  = 1'b1;
            end
        endcase

        sclk_nxt = (state_nxt == SHIFT) ? div_nxt[SCLK_DIV_W-1] : 1'b1;
    end

    assign SS_n    = ss_n_r;
    assign SCLK    = sclk_r;
    assign MOSI    = shft_reg_r[15];
    assign done    = done_r;
    assign rd_data = shft_reg_r;

endmodule

// File: tb/tb_spi_mstr_seq16.sv
// Directed bench for spi_mstr_seq16: mode-3 slave models on a default-width and a 3-bit-divider instance.
module tb_spi_mstr_seq16;

    localparam int LAT5 = 521;
    localparam int LAT3 = 137;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrt_s = 1'b0;
    logic [15:0] cmd_s = 16'h0000;
    logic        miso_s, ss_n_s, sclk_s, mosi_s, done_s;
    logic [15:0] rd_data_s;

    logic        w3_wrt_s = 1'b0;
    logic [15:0] w3_cmd_s = 16'h0000;
    logic        w3_miso_s, w3_ss_n_s, w3_sclk_s, w3_mosi_s, w3_done_s;
    logic [15:0] w3_rd_data_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_mstr_seq16 #(.SCLK_DIV_W(5)) u_dut (
        .clk(clk), .rst(rst), .wrt(wrt_s), .cmd(cmd_s), .MISO(miso_s),
        .SS_n(ss_n_s), .SCLK(sclk_s), .MOSI(mosi_s), .done(done_s), .rd_data(rd_data_s)
    );

    spi_mstr_seq16 #(.SCLK_DIV_W(3)) u_dut_w3 (
        .clk(clk), .rst(rst), .wrt(w3_wrt_s), .cmd(w3_cmd_s), .MISO(w3_miso_s),
        .SS_n(w3_ss_n_s), .SCLK(w3_sclk_s), .MOSI(w3_mosi_s), .done(w3_done_s), .rd_data(w3_rd_data_s)
    );

    // Mode-3 slave for the default instance: drive on SCLK fall, capture on SCLK rise
    logic [15:0] slv_tx_s = 16'h0000, slv_txsh_s = 16'h0000, slv_rx_s = 16'h0000;
    logic        slv_bit_s = 1'b0;
    int          slv_rises_s = 0;
    always @(negedge sclk_s or negedge ss_n_s) begin
        if (sclk_s) slv_txsh_s = slv_tx_s;
        else if (!ss_n_s) begin
            slv_bit_s  = slv_txsh_s[15];
            slv_txsh_s = {slv_txsh_s[14:0], 1'b0};
        end
    end
    always @(posedge sclk_s) if (!ss_n_s) begin
        slv_rx_s = {slv_rx_s[14:0], mosi_s};
        slv_rises_s++;
    end
    assign miso_s = slv_bit_s;

    // Same slave for the 3-bit-divider instance
    logic [15:0] w3_tx_s = 16'h0000, w3_txsh_s = 16'h0000, w3_rx_s = 16'h0000;
    logic        w3_bit_s = 1'b0;
    int          w3_rises_s = 0;
    always @(negedge w3_sclk_s or negedge w3_ss_n_s) begin
        if (w3_sclk_s) w3_txsh_s = w3_tx_s;
        else if (!w3_ss_n_s) begin
            w3_bit_s  = w3_txsh_s[15];
            w3_txsh_s = {w3_txsh_s[14:0], 1'b0};
        end
    end
    always @(posedge w3_sclk_s) if (!w3_ss_n_s) begin
        w3_rx_s = {w3_rx_s[14:0], w3_mosi_s};
        w3_rises_s++;
    end
    assign w3_miso_s = w3_bit_s;

    // Free-running monitors: SS_n-low cycles and SCLK low while deselected
    int ss_low5 = 0, ss_low3 = 0, idle_err5 = 0, idle_err3 = 0;
    always @(negedge clk) begin
        if (ss_n_s === 1'b1 && sclk_s !== 1'b1) idle_err5++;
        if (w3_ss_n_s === 1'b1 && w3_sclk_s !== 1'b1) idle_err3++;
        if (ss_n_s === 1'b0) ss_low5++;
        if (w3_ss_n_s === 1'b0) ss_low3++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Caller is positioned #1 after a rising clk edge
    task automatic run_frame5(input logic [15:0] c, input logic [15:0] reply, input int busy_at, input string tag);
        int cyc;
        int low_base;
        int rise_base;
        slv_tx_s = reply;
        chk({tag, "_ss_pre"}, 32'(ss_n_s), 32'd1);
        wrt_s = 1'b1;
        cmd_s = c;
        rise_base = slv_rises_s;
        @(posedge clk); #1;
        wrt_s = 1'b0;
        chk({tag, "_accept"}, {30'd0, ss_n_s, done_s}, 32'd0);
        low_base = ss_low5;
        cyc = 0;
        while (done_s !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == busy_at) begin
                wrt_s = 1'b1;
                cmd_s = 16'hFFFF;
            end else begin
                wrt_s = 1'b0;
            end
        end
        wrt_s = 1'b0;
        chk({tag, "_latency"}, 32'(cyc), 32'(LAT5));
        chk({tag, "_ss_low"}, 32'(ss_low5 - low_base), 32'(LAT5));
        chk({tag, "_rises"}, 32'(slv_rises_s - rise_base), 32'd16);
        chk({tag, "_slave_rx"}, {16'd0, slv_rx_s}, {16'd0, c});
        chk({tag, "_rd_data"}, {16'd0, rd_data_s}, {16'd0, reply});
    endtask

    task automatic run_frame3(input logic [15:0] c, input logic [15:0] reply, input string tag);
        int cyc;
        int low_base;
        int rise_base;
        w3_tx_s = reply;
        w3_wrt_s = 1'b1;
        w3_cmd_s = c;
        rise_base = w3_rises_s;
        @(posedge clk); #1;
        w3_wrt_s = 1'b0;
        low_base = ss_low3;
        cyc = 0;
        while (w3_done_s !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(LAT3));
        chk({tag, "_ss_low"}, 32'(ss_low3 - low_base), 32'(LAT3));
        chk({tag, "_rises"}, 32'(w3_rises_s - rise_base), 32'd16);
        chk({tag, "_slave_rx"}, {16'd0, w3_rx_s}, {16'd0, c});
        chk({tag, "_rd_data"}, {16'd0, w3_rd_data_s}, {16'd0, reply});
    endtask

    initial begin
        int base;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", 32'(ss_n_s), 32'd1);
        chk("rst_sclk", 32'(sclk_s), 32'd1);
        chk("rst_done", 32'(done_s), 32'd0);
        chk("rst_rd_data", {16'd0, rd_data_s}, 32'd0);
        chk("rst_mosi", 32'(mosi_s), 32'd0);
        chk("rst_w3_outs", {29'd0, w3_ss_n_s, w3_sclk_s, w3_done_s}, 32'd6);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame5(16'h0D02, 16'h0000, 0, "write");
        repeat (4) @(posedge clk);
        #1;
        run_frame5(16'hA200, 16'h005A, 0, "read");
        repeat (4) @(posedge clk);
        #1;

        run_frame5(16'hA300, 16'h00C3, 0, "b2b_first");
        run_frame5(16'hA400, 16'h003C, 0, "b2b_second");
        repeat (4) @(posedge clk);
        #1;

        run_frame5(16'h1062, 16'h0081, 200, "busy");
        base = ss_low5;
        repeat (50) @(posedge clk);
        #1;
        chk("busy_no_extra_frame", 32'(ss_low5 - base), 32'd0);
        chk("busy_done_held", 32'(done_s), 32'd1);

        wrt_s = 1'b1;
        cmd_s = 16'h2222;
        @(posedge clk); #1;
        wrt_s = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_outs", {29'd0, ss_n_s, sclk_s, done_s}, 32'd6);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame5(16'h1460, 16'h0099, 0, "post_reset");

        run_frame3(16'hC3A5, 16'h5AC3, "w3");

        chk("sclk_idle_high", 32'(idle_err5), 32'd0);
        chk("w3_sclk_idle_high", 32'(idle_err3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mstr_seq16.md
Name: spi_mstr_seq16

Overview:
- 16-bit SPI master that the inertial interface uses to reach the 6-axis inertial sensor.
- The upstream controller presents a command word and pulses wrt. The block runs one full-duplex 16-bit SPI frame, with SS_n framing and SCLK derived from the system clock, then returns the captured MISO word with a done flag.
- It sits directly below the inertial-sensor read/write state machine.
- It uses SPI mode 3: SCLK idles high, MOSI changes on SCLK fall, MISO is sampled on SCLK rise.

Parameters:
- SCLK_DIV_W, 5: SCLK period is 2^SCLK_DIV_W clk cycles (32 by default). Legal range is 3..8.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- wrt  input  1  single-cycle start request; accepted only when idle or done
- cmd  input  16  word to transmit, MSB first; sampled on the accepting edge
- MISO  input  1  serial data from the sensor
- SS_n  output  1  active-low slave select
- SCLK  output  1  serial clock, idle high
- MOSI  output  1  serial data to the sensor, equal to shft_reg[15]
- done  output  1  frame complete; level, held until the next accepted wrt
- rd_data  output  16  word received on MISO; valid while done=1

Behaviour:
- Reset (async, rst=1): state=IDLE, SS_n=1, SCLK=1, done=0, shft_reg=0, div counter=0, bit counter=0. Reset mid-frame aborts immediately with the same values; no partial done is produced.
- Internal registers:
  - div: SCLK_DIV_W bits. While not IDLE, SCLK = div[MSB]; in IDLE and BACK_PORCH SCLK is forced to 1.
  - bit_cnt: 5 bits.
  - shft_reg: 16 bits.
  - miso_smpl: 1 bit.
- States: IDLE, FRONT_PORCH, SHIFT, BACK_PORCH.
- IDLE, on wrt=1:
  - shft_reg<=cmd, div<=2^W-9 (10111b at W=5), bit_cnt<=0, done<=0, SS_n<=0.
  - Go to FRONT_PORCH.
- FRONT_PORCH:
  - div increments each clk.
  - When div==all-ones, the next edge wraps div to 0, producing the first SCLK fall. No shift occurs on this fall because the MSB is already on MOSI.
  - Go to SHIFT.
- SHIFT, div increments each clk:
  - div==01..1 (rise imminent): miso_smpl<=MISO and bit_cnt++.
  - div==all-ones with bit_cnt<16 (fall imminent): shft_reg<={shft_reg[14:0],miso_smpl}.
  - div==all-ones with bit_cnt==16: go to BACK_PORCH handling, described next.
- BACK_PORCH (final edge, bit_cnt==16 at div==all-ones):
  - Do the final shift, set SS_n<=1 and done<=1, and go to IDLE.
  - SCLK stays high; there is no 17th fall.
- Frame shape: exactly 16 SCLK rising edges occur while SS_n=0.
- Latency: done rises 9 + 16*2^W clk edges after the accepting edge (521 at W=5). SS_n is low for exactly that many cycles.
- rd_data = shft_reg at all times; it is meaningful only while done=1.
- MOSI = shft_reg[15] and changes only on the SCLK-fall edges or on load.
- wrt while busy (FRONT_PORCH/SHIFT): ignored; the frame in flight is unaffected.
- wrt in the same cycle as done=1 (IDLE): accepted. done clears on that edge, which allows back-to-back frames with SS_n high for at least 1 clk between them.
- Command framing: cmd[15]=1 marks a read, and the sensor's reply appears in rd_data[7:0] of the same frame. The master does not interpret cmd.

Decomposition:
- spi_pkg holds the state enum (IDLE, FRONT_PORCH, SHIFT, BACK_PORCH) and the constants for FRONT_PORCH_LOAD and the rise/fall decode values, expressed as functions of SCLK_DIV_W.
- No sub-module is needed: the divider, shifter and FSM stay in one module.

Test Plan:
- Bench model: a mode-3 slave that shifts in MOSI on SCLK rise and drives MISO on SCLK fall.
- Write frame: cmd=16'h0D02 with slave reply 16'h0000 -> slave captures 16'h0D02; done=1 at edge 521; 16 SCLK rises while SS_n=0; SCLK=1 whenever SS_n=1.
- Read frame: cmd=16'hA200 with slave shifting out 16'h005A -> rd_data=16'h005A with done=1; MOSI bits equal 1010_0010_0000_0000 in order.
- Back-to-back: wrt with 16'hA300, then a second wrt on the done cycle with 16'hA400 -> two frames; SS_n high for at least 1 clk between them; each rd_data matches the slave model.
- Busy wrt: pulse wrt with 16'hFFFF at cycle 200 of a 16'h1062 frame -> slave still sees 16'h1062; no extra frame follows.
- Reset mid-frame: assert rst at cycle 300 -> SS_n=1, SCLK=1, done=0 asynchronously. A new wrt with 16'h1460 after release completes normally at 521 clk.
- Parameter sweep: SCLK_DIV_W=3 -> SCLK period 8 clk; done at 9+128=137 clk; data is correct.
